// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and lane helpers for the MEM-stage
// data-memory access sequencer.
package dmem_access_ctrl_pkg;

  localparam logic [1:0] WRITE_IDLE = 2'b00;
  localparam logic [1:0] WRITE_BYTE = 2'b01;
  localparam logic [1:0] WRITE_HALF = 2'b10;
  localparam logic [1:0] WRITE_WORD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  off;
  } mem_req_t;

  function automatic logic [3:0] lane_be(
    input size_t      sz,
    input logic [1:0] a
  );
    case (sz)
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(
    input size_t       sz,
    input logic [31:0] d
  );
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Single-port data-memory bus: req/ack handshake,
// byte enables, word address and data.
interface dmem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_load_formatter.sv
// Picks the byte/half of a raw memory word and
// sign- or zero-extends it according to funct3.
module dmem_access_ctrl_load_formatter
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_raw[7:0];
    unique case (i_off)
      2'd0: w_b = i_raw[7:0];
      2'd1: w_b = i_raw[15:8];
      2'd2: w_b = i_raw[23:16];
      2'd3: w_b = i_raw[31:24];
    endcase
    w_h = i_off[1] ? i_raw[31:16] : i_raw[15:0];
    o_data = i_raw;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_b[7]}}, w_b};
      F3_LH:   o_data = {{16{w_h[15]}}, w_h};
      F3_LBU:  o_data = {24'd0, w_b};
      F3_LHU:  o_data = {16'd0, w_h};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: issues one aligned access,
// stalls until ack or timeout, formats the load.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic [1:0]        mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  dmem_access_ctrl_if.master dmem
);

  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  mem_req_t    r_rq;
  logic        r_req;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;

  logic        w_wr;
  logic        w_access;
  logic        w_bad;
  logic        w_mis;
  logic        w_start;
  logic        w_tmo;
  size_t       w_size;
  logic [31:0] w_fmt;

  assign w_wr     = (mem_write_i != WRITE_IDLE);
  assign w_access = w_wr | mem_read_i;

  // Store size wins over load size when both are flagged
  always_comb begin
    w_size = SZ_W;
    w_bad  = 1'b0;
    if (w_wr) begin
      unique case (1'b1)
        (mem_write_i == WRITE_BYTE): w_size = SZ_B;
        (mem_write_i == WRITE_HALF): w_size = SZ_H;
        default:                     w_size = SZ_W;
      endcase
    end else begin
      unique case (1'b1)
        (funct3_i == F3_LB),
        (funct3_i == F3_LBU): w_size = SZ_B;
        (funct3_i == F3_LH),
        (funct3_i == F3_LHU): w_size = SZ_H;
        (funct3_i == F3_LW):  w_size = SZ_W;
        default:              w_bad  = 1'b1;
      endcase
    end
  end

  assign w_mis = w_access & (w_bad
    | ((w_size == SZ_H) & addr_i[0])
    | ((w_size == SZ_W) & (addr_i[1:0] != 2'b00)));

  assign w_start = (r_state == S_IDLE) & w_access & ~w_mis;
  assign w_tmo   = (r_cnt == LIM);

  dmem_access_ctrl_load_formatter u_fmt (
    .i_raw    (dmem.rdata),
    .i_off    (r_rq.off),
    .i_funct3 (r_rq.f3),
    .o_data   (w_fmt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    misaligned_o = 1'b0;
    bus_err_o    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_mis) begin
            misaligned_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            w_next  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (dmem.ack || w_tmo) w_next = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        bus_err_o = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rq    <= '0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
    end else if (w_start) begin
      r_rq.we    <= w_wr;
      r_rq.be    <= lane_be(w_size, addr_i[1:0]);
      r_rq.addr  <= {addr_i[31:2], 2'b00};
      r_rq.wdata <= lane_wdata(w_size, wdata_i);
      r_rq.f3    <= funct3_i;
      r_rq.off   <= addr_i[1:0];
      r_req      <= 1'b1;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
    end else if (r_state == S_BUSY) begin
      if (dmem.ack) begin
        r_req   <= 1'b0;
        r_rdata <= r_rq.we ? 32'd0 : w_fmt;
      end else if (w_tmo) begin
        r_req   <= 1'b0;
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign dmem.req   = r_req;
  assign dmem.we    = r_rq.we;
  assign dmem.be    = r_rq.be;
  assign dmem.addr  = r_rq.addr;
  assign dmem.wdata = r_rq.wdata;
  assign rdata_o    = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table,
// timeout/reset sequences and random accesses.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        stall, done, mis, berr;
  logic [31:0] rdata;
  logic        stall4, done4, mis4, berr4;
  logic [31:0] rdata4;

  dmem_access_ctrl_if bus ();
  dmem_access_ctrl_if bus4 ();

  dmem_access_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .rdata_o      (rdata),
    .done_o       (done),
    .misaligned_o (mis),
    .bus_err_o    (berr),
    .dmem         (bus.master)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall4),
    .rdata_o      (rdata4),
    .done_o       (done4),
    .misaligned_o (mis4),
    .bus_err_o    (berr4),
    .dmem         (bus4.master)
  );

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        rd;
    logic [1:0]  wr;
    logic [2:0]  f3;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] raw;
    int          dly;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 2'b00;
    funct3    = 3'b000;
    addr      = 32'd0;
    wdata     = 32'd0;
  endtask

  // Reference: derive size from the op, then do plain arithmetic
  task automatic model(input logic rd, input logic [1:0] wr,
                       input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] raw,
                       output logic emis, output logic [3:0] ebe,
                       output logic [31:0] ewd, output logic [31:0] erd);
    int n;
    int a;
    bit bad;
    bit sgn;
    longint v;
    bad = 0;
    sgn = 0;
    n   = 4;
    a   = int'(ad % 4);
    if (wr != 0) begin
      n = (wr == 1) ? 1 : (wr == 2) ? 2 : 4;
    end else begin
      case (f3)
        3'd0: begin n = 1; sgn = 1; end
        3'd1: begin n = 2; sgn = 1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: bad = 1;
      endcase
    end
    emis = (rd || wr != 0) && (bad || (a % n) != 0);
    ebe  = 4'(((1 << n) - 1) << a);
    if (n == 1)      ewd = 32'(wd[7:0]) * 32'h01010101;
    else if (n == 2) ewd = 32'(wd[15:0]) * 32'h00010001;
    else             ewd = wd;
    if (wr != 0) begin
      erd = 32'd0;
    end else begin
      v = (longint'(raw) >> (8 * a)) & ((64'd1 << (8 * n)) - 1);
      if (sgn && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
      erd = v[31:0];
    end
  endtask

  task automatic run_access(input logic rd, input logic [1:0] wr,
                            input logic [2:0] f3, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [31:0] raw,
                            input int dly, input logic emis,
                            input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] erd);
    int nst;
    int nrq;
    logic ewe;
    ewe = (wr != 2'b00);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = ad;
    wdata     = wd;
    bus.ack   = 1'b0;
    bus.rdata = raw;
    #1;
    if (emis) begin
      chk("mis_flag", 32'(mis), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_req", 32'(bus.req), 32'd0);
      @(negedge clk);
      #1;
      chk("mis_req_next", 32'(bus.req), 32'd0);
      chk("mis_flag_next", 32'(mis), 32'd1);
      idle_inputs();
      return;
    end
    chk("iss_stall", 32'(stall), 32'd1);
    chk("iss_mis", 32'(mis), 32'd0);
    nst = 1;
    nrq = 0;
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      bus.ack = (k == dly);
      #1;
      nst += int'(stall);
      nrq += int'(bus.req);
      chk("busy_done", 32'(done), 32'd0);
      if (k == 0 || k == dly) begin
        chk("be", 32'(bus.be), 32'(ebe));
        chk("addr", bus.addr, {ad[31:2], 2'b00});
        chk("we", 32'(bus.we), 32'(ewe));
        if (ewe) chk("wdata", bus.wdata, ewd);
      end
    end
    @(negedge clk);
    bus.ack = 1'b0;
    #1;
    chk("done", 32'(done), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_err", 32'(berr), 32'd0);
    chk("done_req", 32'(bus.req), 32'd0);
    chk("rdata", rdata, erd);
    chk("stall_cycles", 32'(nst), 32'(dly + 2));
    chk("req_cycles", 32'(nrq), 32'(dly + 1));
    @(negedge clk);
    idle_inputs();
    #1;
    chk("no_reissue", 32'({bus.req, stall, done}), 32'd0);
  endtask

  initial begin
    logic        r_rd;
    logic [1:0]  r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_ad, r_wd, r_raw;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;

    tbl[0]  = '{0, 2'b11, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                0, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 2'b01, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0,
                0, 4'h8, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{1, 2'b00, 3'b000, 32'h102, 32'h0, 32'h00800000, 0,
                0, 4'h4, 32'h0, 32'hFFFFFF80};
    tbl[3]  = '{1, 2'b00, 3'b100, 32'h102, 32'h0, 32'h00800000, 0,
                0, 4'h4, 32'h0, 32'h00000080};
    tbl[4]  = '{1, 2'b00, 3'b101, 32'h102, 32'h0, 32'hBEEF0000, 5,
                0, 4'hC, 32'h0, 32'h0000BEEF};
    tbl[5]  = '{1, 2'b00, 3'b010, 32'h101, 32'h0, 32'h0, 0,
                1, 4'h0, 32'h0, 32'h0};
    tbl[6]  = '{0, 2'b10, 3'b000, 32'h102, 32'h00001234, 32'h0, 2,
                0, 4'hC, 32'h12341234, 32'h0};
    tbl[7]  = '{1, 2'b00, 3'b001, 32'h100, 32'h0, 32'h00008001, 1,
                0, 4'h3, 32'h0, 32'hFFFF8001};
    tbl[8]  = '{1, 2'b00, 3'b011, 32'h100, 32'h0, 32'h0, 0,
                1, 4'h0, 32'h0, 32'h0};
    tbl[9]  = '{0, 2'b10, 3'b000, 32'h101, 32'h0, 32'h0, 0,
                1, 4'h0, 32'h0, 32'h0};
    tbl[10] = '{1, 2'b01, 3'b011, 32'h201, 32'h0000007E, 32'h55555555, 0,
                0, 4'h2, 32'h7E7E7E7E, 32'h0};
    tbl[11] = '{1, 2'b00, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1,
                0, 4'hF, 32'h0, 32'hCAFEF00D};

    rst_n      = 1'b0;
    idle_inputs();
    bus.ack    = 1'b0;
    bus.rdata  = 32'd0;
    bus4.ack   = 1'b0;
    bus4.rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_be", 32'(bus.be), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", 32'({stall, done, mis, berr}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].ad, tbl[i].wd,
                 tbl[i].raw, tbl[i].dly, tbl[i].mis, tbl[i].be,
                 tbl[i].ewd, tbl[i].erd);

    // Stray ack while idle must not disturb anything
    @(negedge clk);
    bus.ack   = 1'b1;
    bus.rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus.ack = 1'b0;
    #1;
    chk("stray_done", 32'(done), 32'd0);
    chk("stray_req", 32'(bus.req), 32'd0);
    chk("stray_rdata", rdata, tbl[11].erd);

    for (int i = 0; i < 40; i++) begin
      r_rd  = 1'($urandom_range(0, 1));
      r_wr  = 2'($urandom_range(0, 3));
      if (!r_rd && r_wr == 2'b00) r_rd = 1'b1;
      r_f3  = 3'($urandom_range(0, 7));
      r_ad  = $urandom;
      r_wd  = $urandom;
      r_raw = $urandom;
      model(r_rd, r_wr, r_f3, r_ad, r_wd, r_raw, e_mis, e_be, e_wd, e_rd);
      run_access(r_rd, r_wr, r_f3, r_ad, r_wd, r_raw,
                 int'($urandom_range(0, 6)), e_mis, e_be, e_wd, e_rd);
    end

    // TIMEOUT=4 instance: good load, then timeout
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_read  = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h300;
    @(negedge clk);
    bus4.ack   = 1'b1;
    bus4.rdata = 32'h12345678;
    @(negedge clk);
    bus4.ack = 1'b0;
    #1;
    chk("t4_ok_done", 32'(done4), 32'd1);
    chk("t4_ok_rdata", rdata4, 32'h12345678);
    chk("t4_ok_err", 32'(berr4), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h304;
    #1;
    chk("to_issue", 32'(stall4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("to_req", 32'(bus4.req), 32'd1);
      chk("to_busy", 32'({stall4, done4}), 32'b10);
    end
    @(negedge clk);
    #1;
    chk("to_done", 32'(done4), 32'd1);
    chk("to_err", 32'(berr4), 32'd1);
    chk("to_rdata", rdata4, 32'd0);
    chk("to_req_drop", 32'(bus4.req), 32'd0);
    chk("to_stall", 32'(stall4), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("to_idle", 32'({bus4.req, stall4, done4}), 32'd0);

    // Reset in BUSY, then a late ack
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h308;
    @(negedge clk);
    #1;
    chk("rb_req1", 32'(bus4.req), 32'd1);
    @(negedge clk);
    #1;
    chk("rb_req2", 32'(bus4.req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    chk("rb_req_drop", 32'(bus4.req), 32'd0);
    chk("rb_stall", 32'(stall4), 32'd0);
    chk("rb_req_main", 32'(bus.req), 32'd0);
    bus4.ack   = 1'b1;
    bus4.rdata = 32'hFFFFFFFF;
    bus.ack    = 1'b1;
    @(negedge clk);
    bus4.ack = 1'b0;
    bus.ack  = 1'b0;
    #1;
    chk("late_done", 32'(done4), 32'd0);
    chk("late_rdata", rdata4, 32'd0);
    chk("late_stall", 32'(stall4), 32'd0);
    @(negedge clk);
    #1;
    chk("late_done2", 32'({done4, done, bus4.req}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
